// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority over a small
// MDU result queue, with WAW squash, decode hazard detection and anti-starvation drain.
module wb_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    output logic        pipe_stall_o,
    input  logic        mdu_valid_i,
    output logic        mdu_ready_o,
    input  logic [4:0]  mdu_waddr_i,
    input  logic [31:0] mdu_wdata_i,
    input  logic [4:0]  hz_addr1_i,
    input  logic [4:0]  hz_addr2_i,
    output logic        hazard_o,
    output logic        we_o,
    output logic [4:0]  waddr_o,
    output logic [31:0] wdata_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic [4:0]            q_addr_q [FIFO_DEPTH];
    logic [31:0]           q_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] q_live_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  stall_q, stall_d;
    logic                  we_q, we_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic head_vld, head_live, pipe_wr, mdu_acc, mdu_store, pop, blocked;

    assign mdu_ready_o  = (cnt_q < CW'(FIFO_DEPTH));
    assign pipe_stall_o = stall_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;

    always_comb begin
        head_vld  = (cnt_q != '0);
        head_live = head_vld && q_live_q[rd_ptr_q];
        // A stalled pipeline is ignored entirely, so the stall cycle behaves like an idle pipe.
        pipe_wr   = !stall_q && pipe_we_i && (pipe_waddr_i != 5'd0);
        mdu_acc   = mdu_valid_i && mdu_ready_o;
        mdu_store = mdu_acc && (mdu_waddr_i != 5'd0) &&
                    !(pipe_wr && (pipe_waddr_i == mdu_waddr_i));
        pop       = 1'b0;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        if (pipe_wr) begin
            we_d    = 1'b1;
            waddr_d = pipe_waddr_i;
            wdata_d = pipe_wdata_i;
            pop     = head_vld && !head_live;
        end else if (head_live) begin
            we_d    = 1'b1;
            waddr_d = q_addr_q[rd_ptr_q];
            wdata_d = q_data_q[rd_ptr_q];
            pop     = 1'b1;
        end else begin
            pop     = head_vld;
        end
        cnt_d   = cnt_q + CW'(mdu_store) - CW'(pop);
        blocked = pipe_wr && head_live;
        stall_d = blocked && (starve_q == SW'(STARVE_MAX - 1));
        if (!head_vld || pop || stall_d) starve_d = '0;
        else if (blocked)                starve_d = starve_q + SW'(1);
        else                             starve_d = starve_q;
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q_live_q[i] &&
                (((hz_addr1_i != 5'd0) && (q_addr_q[i] == hz_addr1_i)) ||
                 ((hz_addr2_i != 5'd0) && (q_addr_q[i] == hz_addr2_i))))
                hazard_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_live_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_addr_q[i] <= '0;
                q_data_q[i] <= '0;
            end
        end else begin
            // Squash first; a same-cycle pop or enqueue below overrides the slot it touches.
            for (int i = 0; i < FIFO_DEPTH; i++)
                if (pipe_wr && (q_addr_q[i] == pipe_waddr_i)) q_live_q[i] <= 1'b0;
            if (pop) begin
                q_live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q           <= rd_ptr_q + PW'(1);
            end
            if (mdu_store) begin
                q_addr_q[wr_ptr_q] <= mdu_waddr_i;
                q_data_q[wr_ptr_q] <= mdu_wdata_i;
                q_live_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with hand-computed expectations.
module tb_wb_write_arbiter;
    logic        clk, rst;
    logic        pipe_we_i, pipe_stall_o, mdu_valid_i, mdu_ready_o, hazard_o, we_o;
    logic [4:0]  pipe_waddr_i, mdu_waddr_i, hz_addr1_i, hz_addr2_i, waddr_o;
    logic [31:0] pipe_wdata_i, mdu_wdata_i, wdata_o;
    int n_chk = 0, n_err = 0;

    wb_write_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .pipe_stall_o(pipe_stall_o),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
        .mdu_waddr_i(mdu_waddr_i), .mdu_wdata_i(mdu_wdata_i),
        .hz_addr1_i(hz_addr1_i), .hz_addr2_i(hz_addr2_i), .hazard_o(hazard_o),
        .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we_i = we; pipe_waddr_i = a; pipe_wdata_i = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        mdu_valid_i = v; mdu_waddr_i = a; mdu_wdata_i = d;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, we_o, we);
        chk({tag, ".waddr"}, waddr_o, a);
        chk({tag, ".wdata"}, wdata_o, d);
    endtask

    initial begin
        rst = 1'b0;
        pipe(0, 0, 0); mdu(0, 0, 0);
        hz_addr1_i = 0; hz_addr2_i = 0;
        tick(); tick();
        chk_out("reset", 0, 0, 0);
        chk("reset.stall", pipe_stall_o, 0);
        rst = 1'b1;
        #1;
        chk("reset.ready", mdu_ready_o, 1);

        // 1: pipe-only write
        pipe(1, 5, 32'h11);
        tick();
        chk_out("t1", 1, 5, 32'h11);
        chk("t1.ready", mdu_ready_o, 1);
        pipe(0, 0, 0);
        tick();
        chk_out("t1.idle", 0, 5, 32'h11);

        // 2: fill queue behind pipe writes, then drain in order
        pipe(1, 20, 32'h1); mdu(1, 7, 32'hA);
        tick();
        pipe(1, 21, 32'h2); mdu(1, 8, 32'hB);
        tick();
        chk("t2.full_ready", mdu_ready_o, 0);
        pipe(0, 0, 0); mdu(1, 9, 32'hF);
        #1;
        chk("t2.full_ready_v", mdu_ready_o, 0);
        tick();
        mdu(0, 0, 0);
        chk_out("t2.x7", 1, 7, 32'hA);
        chk("t2.ready_back", mdu_ready_o, 1);
        tick();
        chk_out("t2.x8", 1, 8, 32'hB);
        tick();
        chk("t2.empty_we", we_o, 0);

        // 3: hazard on queued x9, then an x0 result
        pipe(1, 22, 32'h3); mdu(1, 9, 32'h99);
        tick();
        mdu(0, 0, 0); pipe(1, 23, 32'h4); hz_addr2_i = 9;
        #1;
        chk("t3.hz_q", hazard_o, 1);
        tick();
        pipe(0, 0, 0);
        #1;
        chk("t3.hz_blk", hazard_o, 1);
        tick();
        chk_out("t3.x9", 1, 9, 32'h99);
        chk("t3.hz_clr", hazard_o, 0);
        hz_addr2_i = 0; hz_addr1_i = 0;
        mdu(1, 0, 32'h55);
        #1;
        chk("t3.x0_ready", mdu_ready_o, 1);
        chk("t3.x0_hz", hazard_o, 0);
        tick();
        mdu(0, 0, 0);
        chk("t3.x0_we", we_o, 0);
        chk("t3.x0_ready2", mdu_ready_o, 1);
        tick();
        chk("t3.x0_we2", we_o, 0);

        // 4: WAW squash of queued x12 plus a discarded concurrent MDU x12
        mdu(1, 12, 32'h1);
        tick();
        pipe(1, 12, 32'h2); mdu(1, 12, 32'h3); hz_addr1_i = 12;
        #1;
        chk("t4.hz_live", hazard_o, 1);
        tick();
        pipe(0, 0, 0); mdu(0, 0, 0);
        #1;
        chk_out("t4.pipe", 1, 12, 32'h2);
        chk("t4.hz_squash", hazard_o, 0);
        tick();
        chk_out("t4.dead", 0, 12, 32'h2);
        tick();
        chk_out("t4.none", 0, 12, 32'h2);
        chk("t4.ready", mdu_ready_o, 1);
        hz_addr1_i = 0;

        // 5: starvation forces a one-cycle drain
        pipe(1, 1, 32'h100); mdu(1, 3, 32'hC);
        tick();
        mdu(0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            pipe(1, 1, 32'h100 + k);
            tick();
            chk_out($sformatf("t5.blk%0d", k), 1, 1, 32'h100 + k);
            chk($sformatf("t5.stall%0d", k), pipe_stall_o, (k == 4) ? 1 : 0);
        end
        pipe(1, 1, 32'hDEAD);
        tick();
        chk_out("t5.drain", 1, 3, 32'hC);
        chk("t5.stall_off", pipe_stall_o, 0);
        pipe(1, 1, 32'h200);
        tick();
        chk_out("t5.resume", 1, 1, 32'h200);
        chk("t5.stall_off2", pipe_stall_o, 0);
        pipe(0, 0, 0);
        tick();

        // 6: reset with two entries queued
        pipe(1, 24, 32'h5); mdu(1, 13, 32'hD);
        tick();
        pipe(1, 25, 32'h6); mdu(1, 14, 32'hE);
        tick();
        pipe(0, 0, 0); mdu(0, 0, 0);
        chk("t6.full", mdu_ready_o, 0);
        rst = 1'b0;
        #1;
        chk_out("t6.rst", 0, 0, 0);
        chk("t6.rst_stall", pipe_stall_o, 0);
        tick();
        rst = 1'b1; hz_addr1_i = 13; hz_addr2_i = 14;
        #1;
        chk("t6.ready", mdu_ready_o, 1);
        chk("t6.hz", hazard_o, 0);
        tick();
        chk_out("t6.nowr1", 0, 0, 0);
        tick();
        chk_out("t6.nowr2", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
